alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer for the team's 1-bit ALU slice datapath.
- Accepts a WIDTH-bit operand pair and an opcode over a valid/ready handshake.
- Streams the operands LSB-first through a single combinational 1-bit slice, one bit per clock, with a registered carry between bits.
- Reassembles the result word and presents it with carry and zero flags on a second valid/ready handshake to the downstream consumer.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode, see Behaviour.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_z  output  WIDTH  result word.
- out_cout  output  1  final carry (ADD) / no-borrow (SUB); 0 for logic ops.
- out_zero  output  1  out_z == 0.

Behaviour:
- One clock (clk); reset rst_n is asynchronous and active-low.
- Opcodes:
  - 000 ADD
  - 001 SUB, computed as A + ~B + 1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101–111 reserved: result 0, out_cout 0, out_zero 1, same latency as other ops.
- Reset (async, rst_n low): state IDLE; out_valid, out_z, out_cout, out_zero = 0; shift registers, carry and counter cleared. in_ready = 1 once in IDLE.
- Reset mid-operation: the in-flight op is discarded; no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge: latch in_a/in_b into shift registers and latch in_op.
  - Carry ← 1 for SUB, else 0. Counter ← 0. Go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle the slice sees a_sh[0], b_sh[0] (inverted for SUB), carry and the mapped slice op.
  - Slice ops: full-add for ADD/SUB; AND/OR/XOR as given; constant 0 for reserved.
  - Update: res ← {z_bit, res[WIDTH-1:1]}; a_sh/b_sh shift right; carry ← slice cout (ADD/SUB only, else 0); counter++.
  - When counter == WIDTH-1, the same edge moves to DONE and registers out_z (full res), out_cout (final carry), out_zero, and sets out_valid.
- DONE:
  - out_valid = 1.
  - out_z/out_cout/out_zero held stable while out_ready = 0.
  - On out_ready: clear out_valid and go to IDLE. Data outputs keep their last value.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Throughput: minimum one op per WIDTH+2 cycles (no IDLE bypass).
- Operand inputs are ignored outside the accepting edge. in_valid held high during RUN/DONE has no effect.
- Arithmetic: modulo 2^WIDTH. For SUB, out_cout = 1 iff A ≥ B unsigned.

Decomposition:
- Package alu_serial_pkg holds:
  - op_e enum (3-bit: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR).
  - slice_op_e (2-bit: S_AND=00, S_OR=01, S_XOR=10, S_ADD=11).
  - state_e (IDLE, RUN, DONE).
  - An op→slice_op mapping function.
- Sub-module alu_serial_slice: purely combinational 1-bit slice (a, b, cin, s_op → z, cout), instantiated once. Logic ops drive cout = 0.

Test Plan:
- ADD, WIDTH=4, A=7, B=9 → out_z=0, out_cout=1, out_zero=1; out_valid asserted exactly 4 cycles after accept.
- SUB A=5, B=3 → out_z=2, out_cout=1. Then SUB A=3, B=5 → out_z=4'hE, out_cout=0, out_zero=0.
- Logic ops with A=4'hC, B=4'hA: AND → 4'h8; OR → 4'hE; XOR → 4'h6; out_cout=0 for each.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands on the bus. out_z/flags must stay stable and in_ready=0. After release, the next op is accepted in IDLE and yields the correct result.
- rst_n pulsed low after 2 RUN cycles of ADD F+1:
  - Outputs drop to 0 asynchronously and state returns to IDLE.
  - No out_valid for the aborted op.
  - A following ADD 3+4 → out_z=7, out_cout=0.
- Reserved op 3'b111 with A=B=4'hF → out_z=0, out_cout=0, out_zero=1 after 4 cycles.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared types for the bit-serial ALU: opcodes, slice operations, sequencer states,
// plus the mapping from a word-level opcode to the operation the 1-bit slice performs.
package alu_serial_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    S_AND = 2'b00,
    S_OR  = 2'b01,
    S_XOR = 2'b10,
    S_ADD = 2'b11
  } slice_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Reserved opcodes map to S_AND; the sequencer also masks their operand bits to 0.
  function automatic slice_op_e op2slice(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: op2slice = S_ADD;
      OP_AND:         op2slice = S_AND;
      OP_OR:          op2slice = S_OR;
      OP_XOR:         op2slice = S_XOR;
      default:        op2slice = S_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational 1-bit ALU slice: zero latency, no flow control.
// Carry out is only meaningful for S_ADD and is held at 0 for the logic ops.
module alu_serial_slice
  import alu_serial_pkg::*;
(
  input  logic      i_a,
  input  logic      i_b,
  input  logic      i_cin,
  input  slice_op_e i_op,
  output logic      o_z,
  output logic      o_cout
);

  always_comb begin
    o_z    = 1'b0;
    o_cout = 1'b0;
    case (i_op)
      S_AND: o_z = i_a & i_b;
      S_OR:  o_z = i_a | i_b;
      S_XOR: o_z = i_a ^ i_b;
      S_ADD: begin
        o_z    = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
      end
      default: begin
        o_z    = 1'b0;
        o_cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: result valid WIDTH cycles after accept, one op per WIDTH+2 cycles.
// Accepts only in IDLE; the result is held in DONE until out_ready, blocking new requests.
module alu_serial_seq
  import alu_serial_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_cout,
  output logic             out_zero
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_z;
  logic             r_out_cout;
  logic             r_out_zero;

  logic             w_rsvd;
  logic             w_sub;
  logic             w_a_bit;
  logic             w_b_bit;
  slice_op_e        w_sop;
  logic             w_z;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  // Reserved ops zero both operand bits so the AND slice produces a constant 0.
  assign w_rsvd     = (r_op > 3'd4);
  assign w_sub      = (r_op == OP_SUB);
  assign w_a_bit    = r_a_sh[0] & ~w_rsvd;
  assign w_b_bit    = (r_b_sh[0] ^ w_sub) & ~w_rsvd;
  assign w_sop      = op2slice(r_op);
  assign w_res_next = {w_z, r_res[WIDTH-1:1]};

  alu_serial_slice u_slice (
    .i_a    (w_a_bit),
    .i_b    (w_b_bit),
    .i_cin  (r_carry),
    .i_op   (w_sop),
    .o_z    (w_z),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res       <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_cout  <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= in_a;
            r_b_sh  <= in_b;
            r_op    <= in_op;
            r_carry <= (in_op == OP_SUB);
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_next;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          // Final bit: publish the full word in the same edge that leaves RUN.
          if (r_cnt == LAST_BIT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_z     <= w_res_next;
            r_out_cout  <= w_cout;
            r_out_zero  <= (w_res_next == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_cout  = r_out_cout;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: expectations are queued at accept and
// compared when out_valid rises, including the accept-to-valid latency.
module tb_alu_serial_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic         out_cout;
  logic         out_zero;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_cout  (out_cout),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [W-1:0] z;
    logic         c;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_vld = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: plain modular arithmetic on W+1 bits.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] op);
    logic [W:0] r;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} + {1'b0, ~b} + 1'b1;
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [W-1:0] ez, input logic ec);
    int   k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("rdy_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    @(posedge clk);
    #1;
    e.z   = ez;
    e.c   = ec;
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    check("rdy_run", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || !in_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !prev_vld) begin
        if (q.size() == 0) begin
          check("spurious_vld", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("z",    {28'd0, out_z}, {28'd0, e.z});
          check("cout", {31'd0, out_cout}, {31'd0, e.c});
          check("zero", {31'd0, out_zero}, {31'd0, (e.z == '0)});
          check("lat",  cyc - e.acc, W);
        end
      end
      prev_vld = rst_n && out_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    logic [W:0]   m;
    int           k;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld",  {31'd0, out_valid}, 32'd0);
    check("rst_z",    {28'd0, out_z}, 32'd0);
    check("rst_cout", {31'd0, out_cout}, 32'd0);
    check("rst_zero", {31'd0, out_zero}, 32'd0);
    check("rst_rdy",  {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    send(4'd7, 4'd9, 3'b000, 4'h0, 1'b1);
    send(4'd5, 4'd3, 3'b001, 4'h2, 1'b1);
    send(4'd3, 4'd5, 3'b001, 4'hE, 1'b0);
    send(4'hC, 4'hA, 3'b010, 4'h8, 1'b0);
    send(4'hC, 4'hA, 3'b011, 4'hE, 1'b0);
    send(4'hC, 4'hA, 3'b100, 4'h6, 1'b0);
    send(4'hF, 4'hF, 3'b111, 4'h0, 1'b0);
    drain();

    // Backpressure with a pending request on the bus.
    out_ready = 1'b0;
    send(4'd6, 4'd7, 3'b000, 4'hD, 1'b0);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("bp_vld_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd4; in_op = 3'b001;
    repeat (5) begin
      @(negedge clk);
      check("bp_z",   {28'd0, out_z}, 32'hD);
      check("bp_c",   {31'd0, out_cout}, 32'd0);
      check("bp_vld", {31'd0, out_valid}, 32'd1);
      check("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    send(4'd9, 4'd4, 3'b001, 4'h5, 1'b1);
    drain();

    // Abort an ADD F+1 after two RUN cycles.
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'hF; in_b = 4'h1; in_op = 3'b000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_vld", {31'd0, out_valid}, 32'd0);
    check("abort_z",   {28'd0, out_z}, 32'd0);
    check("abort_c",   {31'd0, out_cout}, 32'd0);
    check("abort_rdy", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_novld", {31'd0, out_valid}, 32'd0);
    send(4'd3, 4'd4, 3'b000, 4'h7, 1'b0);
    drain();

    for (int i = 0; i < 12; i++) begin
      ra  = W'($urandom_range(0, 15));
      rb  = W'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      m   = model(ra, rb, rop);
      send(ra, rb, rop, m[W-1:0], m[W]);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
